// File: rtl/cam_buf_wr_nbuf.sv
// Camera frame-buffer writer: crops a window of a 2-byte/pixel stream
// into 16-bit RAM writes rotating across NUM_BUF frame buffers.
module cam_buf_wr_nbuf #(
  parameter int H_ACT   = 480,
  parameter int V_ACT   = 272,
  parameter int X_OFF   = 0,
  parameter int Y_OFF   = 0,
  parameter int NUM_BUF = 2,
  parameter int ADDR_W  = 17
) (
  input  logic               iClk,
  input  logic               wRsn,
  input  logic               cam_vsync_i,
  input  logic               cam_hsync_i,
  input  logic [7:0]         cam_data_i,
  input  logic               byte_swap_i,
  input  logic [NUM_BUF-1:0] buf_rel_i,
  output logic               ram_wr_en_o,
  output logic [ADDR_W-1:0]  ram_wr_addr_o,
  output logic [15:0]        ram_wr_data_o,
  output logic [1:0]         ram_wr_buf_o,
  output logic [NUM_BUF-1:0] buf_full_o,
  output logic               frame_done_o,
  output logic               frame_drop_o,
  output logic               frame_short_o,
  output logic [7:0]         frame_cnt_o,
  output logic [7:0]         drop_cnt_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE, ACTIVE, DROP, DONE
  } state_t;

  localparam logic [15:0] XL = 16'(X_OFF);
  localparam logic [15:0] XH = 16'(X_OFF + H_ACT);
  localparam logic [15:0] YL = 16'(Y_OFF);
  localparam logic [15:0] YH = 16'(Y_OFF + V_ACT);
  localparam logic [ADDR_W:0] PIX_N = (ADDR_W+1)'(H_ACT * V_ACT);
  localparam logic [1:0] WB_LAST = 2'(NUM_BUF - 1);

  state_t state_q;

  logic s1_vs_q, s1_hs_q, s2_vs_q, s2_hs_q;
  logic [7:0] s1_data_q;

  logic phase_q, swap_q;
  logic [7:0] first_q;
  logic [15:0] h_cnt_q, v_cnt_q;
  logic [ADDR_W:0] pix_cnt_q;

  logic pend_v_q;
  logic [15:0] pend_data_q;
  logic [ADDR_W-1:0] pend_addr_q;

  logic [1:0] wb_q;
  logic [NUM_BUF-1:0] buf_full_q, buf_full_d, wb_oh;

  logic vs_fall, vs_rise, hs_fall, in_win, full_at_wb, commit;

  assign vs_fall = !s1_vs_q & s2_vs_q;
  assign vs_rise = s1_vs_q & !s2_vs_q;
  assign hs_fall = !s1_hs_q & s2_hs_q;

  assign in_win = (h_cnt_q >= XL) && (h_cnt_q < XH)
               && (v_cnt_q >= YL) && (v_cnt_q < YH);

  assign wb_oh      = NUM_BUF'(1) << wb_q;
  assign full_at_wb = |(buf_full_q & wb_oh);
  assign commit     = (state_q == DONE) && (pix_cnt_q == PIX_N);

  // A set from a commit beats a release of the same buffer
  always_comb begin
    buf_full_d = buf_full_q & ~buf_rel_i;
    if (commit) buf_full_d = buf_full_d | wb_oh;
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      s1_vs_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
      s2_hs_q   <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vs_q   <= cam_vsync_i;
      s1_hs_q   <= cam_hsync_i;
      s2_vs_q   <= s1_vs_q;
      s2_hs_q   <= s1_hs_q;
      s1_data_q <= cam_data_i;
    end
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      phase_q     <= 1'b0;
      first_q     <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      pix_cnt_q   <= '0;
      pend_v_q    <= 1'b0;
      pend_data_q <= '0;
      pend_addr_q <= '0;
    end else begin
      pend_v_q <= 1'b0;
      if (vs_fall) begin
        phase_q   <= 1'b0;
        h_cnt_q   <= '0;
        v_cnt_q   <= '0;
        pix_cnt_q <= '0;
      end else if (state_q == ACTIVE) begin
        if (hs_fall) v_cnt_q <= v_cnt_q + 16'd1;
        if (!s1_hs_q) begin
          phase_q <= 1'b0;
          h_cnt_q <= '0;
        end else begin
          phase_q <= !phase_q;
          if (!phase_q) begin
            first_q <= s1_data_q;
          end else begin
            h_cnt_q <= h_cnt_q + 16'd1;
            if (in_win) begin
              pend_v_q    <= 1'b1;
              pend_data_q <= swap_q ? {s1_data_q, first_q}
                                    : {first_q, s1_data_q};
              pend_addr_q <= pix_cnt_q[ADDR_W-1:0];
              pix_cnt_q   <= pix_cnt_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      ram_wr_buf_o  <= '0;
    end else begin
      ram_wr_en_o <= pend_v_q && (state_q == ACTIVE) && !vs_rise;
      if (pend_v_q) begin
        ram_wr_addr_o <= pend_addr_q;
        ram_wr_data_o <= pend_data_q;
        ram_wr_buf_o  <= wb_q;
      end
    end
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      state_q       <= IDLE;
      wb_q          <= '0;
      swap_q        <= 1'b0;
      buf_full_q    <= '0;
      frame_done_o  <= 1'b0;
      frame_drop_o  <= 1'b0;
      frame_short_o <= 1'b0;
      frame_cnt_o   <= '0;
      drop_cnt_o    <= '0;
    end else begin
      frame_done_o  <= 1'b0;
      frame_drop_o  <= 1'b0;
      frame_short_o <= 1'b0;
      buf_full_q    <= buf_full_d;
      unique case (state_q)
        IDLE: begin
          if (vs_fall) begin
            if (full_at_wb) begin
              state_q <= DROP;
            end else begin
              state_q <= ACTIVE;
              swap_q  <= byte_swap_i;
            end
          end
        end
        ACTIVE: begin
          if (vs_rise) state_q <= DONE;
        end
        DROP: begin
          if (vs_rise) begin
            frame_drop_o <= 1'b1;
            if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (commit) begin
            frame_done_o <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + 8'd1;
            wb_q <= (wb_q == WB_LAST) ? 2'd0 : wb_q + 2'd1;
          end else begin
            frame_short_o <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_full_o = buf_full_q;
  assign busy_o     = (state_q == ACTIVE);

endmodule

// File: tb/tb_cam_buf_wr_nbuf.sv
// Scoreboard bench: two writers (2 and 3 buffers) on a 4x3 window
// at offset (1,1) of a 6-pixel x 5-line camera stream.
module tb_cam_buf_wr_nbuf;

  typedef struct packed {
    logic [1:0]  b;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs_a = 1'b1, vs_b = 1'b1, hs = 1'b0, swap = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] rel_a = '0;
  logic [2:0] rel_b = '0;

  logic wen_a, done_a, drop_a, short_a, busy_a;
  logic [3:0] waddr_a;
  logic [15:0] wdata_a;
  logic [1:0] wbuf_a, full_a;
  logic [7:0] fcnt_a, dcnt_a;

  logic wen_b, done_b, drop_b, short_b, busy_b;
  logic [3:0] waddr_b;
  logic [15:0] wdata_b;
  logic [1:0] wbuf_b;
  logic [2:0] full_b;
  logic [7:0] fcnt_b, dcnt_b;

  wr_t qa[$], qb[$];
  int ea[$], eb[$];
  wr_t ew_a, ew_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_buf_wr_nbuf #(
    .H_ACT(4), .V_ACT(3), .X_OFF(1), .Y_OFF(1),
    .NUM_BUF(2), .ADDR_W(4)
  ) u_a (
    .iClk(clk), .wRsn(rst_n),
    .cam_vsync_i(vs_a), .cam_hsync_i(hs), .cam_data_i(data),
    .byte_swap_i(swap), .buf_rel_i(rel_a),
    .ram_wr_en_o(wen_a), .ram_wr_addr_o(waddr_a),
    .ram_wr_data_o(wdata_a), .ram_wr_buf_o(wbuf_a),
    .buf_full_o(full_a), .frame_done_o(done_a),
    .frame_drop_o(drop_a), .frame_short_o(short_a),
    .frame_cnt_o(fcnt_a), .drop_cnt_o(dcnt_a), .busy_o(busy_a)
  );

  cam_buf_wr_nbuf #(
    .H_ACT(4), .V_ACT(3), .X_OFF(1), .Y_OFF(1),
    .NUM_BUF(3), .ADDR_W(4)
  ) u_b (
    .iClk(clk), .wRsn(rst_n),
    .cam_vsync_i(vs_b), .cam_hsync_i(hs), .cam_data_i(data),
    .byte_swap_i(swap), .buf_rel_i(rel_b),
    .ram_wr_en_o(wen_b), .ram_wr_addr_o(waddr_b),
    .ram_wr_data_o(wdata_b), .ram_wr_buf_o(wbuf_b),
    .buf_full_o(full_b), .frame_done_o(done_b),
    .frame_drop_o(drop_b), .frame_short_o(short_b),
    .frame_cnt_o(fcnt_b), .drop_cnt_o(dcnt_b), .busy_o(busy_b)
  );

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  // Event codes: 4 = done, 2 = drop, 1 = short
  always @(negedge clk) begin
    if (rst_n) begin
      if (wen_a) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_wr_extra got addr %0d want none", waddr_a);
        end else begin
          ew_a = qa.pop_front();
          chk("a_wr_buf", int'(wbuf_a), int'(ew_a.b));
          chk("a_wr_addr", int'(waddr_a), int'(ew_a.a));
          chk("a_wr_data", int'(wdata_a), int'(ew_a.d));
        end
      end
      if ({done_a, drop_a, short_a} != 3'b0) begin
        if (ea.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_event got %0d want none",
                   {done_a, drop_a, short_a});
        end else begin
          chk("a_event", int'({done_a, drop_a, short_a}), ea.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wen_b) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_wr_extra got addr %0d want none", waddr_b);
        end else begin
          ew_b = qb.pop_front();
          chk("b_wr_buf", int'(wbuf_b), int'(ew_b.b));
          chk("b_wr_addr", int'(waddr_b), int'(ew_b.a));
          chk("b_wr_data", int'(wdata_b), int'(ew_b.d));
        end
      end
      if ({done_b, drop_b, short_b} != 3'b0) begin
        if (eb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_event got %0d want none",
                   {done_b, drop_b, short_b});
        end else begin
          chk("b_event", int'({done_b, drop_b, short_b}), eb.pop_front());
        end
      end
    end
  end

  // Expected writes for nw window lines, pixels 1..4 of each line
  task automatic expect_wr(input bit sel, input int nw,
                           input int b, input bit sw);
    wr_t e;
    for (int v = 0; v < nw; v++) begin
      for (int x = 1; x <= 4; x++) begin
        e.b = 2'(b);
        e.a = 4'(v * 4 + x - 1);
        e.d = sw ? {8'(x), 8'(8'hA0 + x)} : {8'(8'hA0 + x), 8'(x)};
        if (sel) qb.push_back(e);
        else qa.push_back(e);
      end
    end
  endtask

  task automatic chk_zero_a(input string n);
    chk({n, "_wen"}, int'(wen_a), 0);
    chk({n, "_full"}, int'(full_a), 0);
    chk({n, "_fcnt"}, int'(fcnt_a), 0);
    chk({n, "_dcnt"}, int'(dcnt_a), 0);
    chk({n, "_busy"}, int'(busy_a), 0);
    chk({n, "_pulses"}, int'({done_a, drop_a, short_a}), 0);
    chk({n, "_addr_data"}, int'({waddr_a, wdata_a, wbuf_a}), 0);
  endtask

  task automatic frame(input bit sel, input int nl, input bit sw,
                       input bit tog, input int rst_line);
    swap = sw;
    repeat (2) @(negedge clk);
    if (sel) vs_b = 1'b0;
    else vs_a = 1'b0;
    repeat (6) @(negedge clk);
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) begin
        chk("rst_busy_before", int'(busy_a), 1);
        rst_n = 1'b0;
        #1;
        chk_zero_a("rst_now");
        repeat (3) @(negedge clk);
        chk_zero_a("rst_held");
        rst_n = 1'b1;
      end
      if (l == 1 && tog) swap = 1'b0;
      hs = 1'b1;
      for (int p = 0; p < 6; p++) begin
        data = 8'(8'hA0 + p);
        @(negedge clk);
        data = 8'(p);
        @(negedge clk);
      end
      hs = 1'b0;
      data = '0;
      repeat (4) @(negedge clk);
    end
    vs_a = 1'b1;
    vs_b = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic rel_pulse(input bit sel, input int mask);
    if (sel) rel_b = 3'(mask);
    else rel_a = 2'(mask);
    @(negedge clk);
    rel_a = '0;
    rel_b = '0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero_a("reset");
    chk("reset_b_full", int'(full_b), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    expect_wr(0, 3, 0, 0); ea.push_back(4);
    frame(0, 5, 0, 0, -1);
    chk("f1_full", int'(full_a), 1);
    chk("f1_fcnt", int'(fcnt_a), 1);

    expect_wr(0, 2, 1, 0); ea.push_back(1);
    frame(0, 3, 0, 0, -1);
    chk("short_full", int'(full_a), 1);
    chk("short_fcnt", int'(fcnt_a), 1);

    expect_wr(0, 3, 1, 0); ea.push_back(4);
    frame(0, 5, 0, 0, -1);
    chk("f2_full", int'(full_a), 3);
    chk("f2_fcnt", int'(fcnt_a), 2);

    ea.push_back(2);
    frame(0, 5, 0, 0, -1);
    chk("drop_dcnt", int'(dcnt_a), 1);
    chk("drop_full", int'(full_a), 3);
    chk("drop_fcnt", int'(fcnt_a), 2);

    rel_pulse(0, 1);
    chk("rel0_full", int'(full_a), 2);
    expect_wr(0, 3, 0, 0); ea.push_back(4);
    frame(0, 5, 0, 0, -1);
    chk("f4_full", int'(full_a), 3);
    chk("f4_fcnt", int'(fcnt_a), 3);

    rel_pulse(0, 3);
    chk("relall_full", int'(full_a), 0);
    expect_wr(0, 3, 1, 1); ea.push_back(4);
    frame(0, 5, 1, 1, -1);
    chk("swap_full", int'(full_a), 2);
    chk("swap_fcnt", int'(fcnt_a), 4);

    for (int i = 0; i < 4; i++) begin
      expect_wr(1, 3, i % 3, 0); eb.push_back(4);
      frame(1, 5, 0, 0, -1);
      chk("rot_full_set", int'(full_b), 1 << (i % 3));
      rel_pulse(1, 1 << (i % 3));
      chk("rot_full_rel", int'(full_b), 0);
    end
    chk("rot_fcnt", int'(fcnt_b), 4);
    chk("rot_dcnt", int'(dcnt_b), 0);

    frame(0, 5, 0, 0, 0);
    chk("post_rst_busy", int'(busy_a), 0);
    chk("post_rst_full", int'(full_a), 0);
    expect_wr(0, 3, 0, 0); ea.push_back(4);
    frame(0, 5, 0, 0, -1);
    chk("post_rst_full2", int'(full_a), 1);
    chk("post_rst_fcnt", int'(fcnt_a), 1);

    repeat (4) @(negedge clk);
    chk("a_wr_left", qa.size(), 0);
    chk("b_wr_left", qb.size(), 0);
    chk("a_ev_left", ea.size(), 0);
    chk("b_ev_left", eb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_buf_wr_nbuf.md
Name: cam_buf_wr_nbuf

Overview:
Parametrised successor of the camera frame-buffer writer. It captures an 8-bit, two-bytes-per-pixel camera stream (VSYNC high = blanking, HSYNC high = line valid) and crops a configurable window into 16-bit RAM writes. Writes rotate across NUM_BUF frame buffers, with per-buffer full/release handshakes, frame dropping when no buffer is free, short-frame detection and selectable byte order. It sits between the camera pins and the frame-buffer RAMs, and feeds the display-side buffer reader.

Parameters:
H_ACT, 480, pixels per stored line
V_ACT, 272, stored lines per frame
X_OFF, 0, first captured pixel index within a line
Y_OFF, 0, first captured line index within a frame
NUM_BUF, 2, number of frame buffers (legal 2..4)
ADDR_W, 17, RAM address width (2^ADDR_W >= H_ACT*V_ACT)

Ports:
iClk  in  1  system/pixel-byte clock
wRsn  in  1  reset, asynchronous, active-low
cam_vsync_i  in  1  frame sync; high = blanking
cam_hsync_i  in  1  line valid
cam_data_i  in  8  camera byte
byte_swap_i  in  1  0: first byte goes to [15:8]; 1: first byte goes to [7:0]; sampled at frame start
buf_rel_i  in  NUM_BUF  1-cycle pulse per buffer from reader; clears that buffer's full flag
ram_wr_en_o  out  1  write strobe
ram_wr_addr_o  out  ADDR_W  pixel offset within the target buffer
ram_wr_data_o  out  16  pixel
ram_wr_buf_o  out  2  target buffer index
buf_full_o  out  NUM_BUF  buffer holds a complete, unreleased frame
frame_done_o  out  1  1-cycle pulse: frame committed
frame_drop_o  out  1  1-cycle pulse: frame discarded because no buffer was free
frame_short_o  out  1  1-cycle pulse: frame ended with fewer than H_ACT*V_ACT pixels
frame_cnt_o  out  8  committed frames, wraps at 255
drop_cnt_o  out  8  dropped frames, saturates at 255
busy_o  out  1  state is ACTIVE

Behaviour:
- Reset: all outputs 0. State IDLE, write buffer index wb = 0. Internal sync registers reset with vsync = 0, so no false edge is seen after reset.
- Input pipeline: pins registered into s1, s1 registered into s2. vs_fall = !s1.vs & s2.vs; vs_rise = s1.vs & !s2.vs; hs_fall = !s1.hs & s2.hs.
- FSM:
  - IDLE: on vs_fall, if buf_full[wb] = 0 go to ACTIVE and latch byte_swap_i; otherwise go to DROP.
  - ACTIVE: on vs_rise go to DONE.
  - DROP: on vs_rise pulse frame_drop_o, drop_cnt += 1 (saturating), go to IDLE.
  - DONE (1 cycle): if pix_cnt = H_ACT*V_ACT, set buf_full[wb], pulse frame_done_o, frame_cnt += 1, wb = (wb+1) mod NUM_BUF. Otherwise pulse frame_short_o, leave buf_full and wb unchanged (the buffer is rewritten next frame). Go to IDLE.
- Counters (ACTIVE only; all clear on vs_fall):
  - phase toggles each cycle s1.hs = 1 and is forced to 0 when s1.hs = 0.
  - h_cnt += 1 on phase = 1 and clears when s1.hs = 0.
  - v_cnt += 1 on hs_fall.
- Write rule:
  - Window: X_OFF <= h_cnt < X_OFF+H_ACT and Y_OFF <= v_cnt < Y_OFF+V_ACT.
  - phase = 0: hold s1.data in the first-byte register.
  - phase = 1 and inside window: next cycle ram_wr_en_o = 1, data = {first, second} (swapped if the latched byte_swap = 1), addr = pix_cnt, buf = wb; then pix_cnt += 1.
  - Latency: second byte at the pins at edge k gives the strobe after edge k+2.
  - ram_wr_en_o is never high in IDLE, DROP or DONE.
  - pix_cnt cannot exceed H_ACT*V_ACT because of the window; odd trailing bytes in a line are ignored.
- Release: buf_rel_i[i] clears buf_full[i] the next cycle. If a set and a release of the same buffer fall in the same cycle, set wins. Release of a non-full buffer is ignored.
- Reset mid-frame: the partial frame is abandoned, all flags clear, and capture resumes at the next vs_fall.

Test Plan:
- H_ACT=4, V_ACT=3, X_OFF=1, Y_OFF=1; 5 lines x 6 pixels, byte pairs {0xA0+n, n} -> exactly 12 writes, addr 0..11, first data 0xA101, buf 0; frame_done_o pulse; buf_full_o = 01; frame_cnt_o = 1.
- NUM_BUF=3; 4 full frames, buf_rel_i pulsed for each buffer after its frame_done_o -> ram_wr_buf_o sequence 0,1,2,0; no drops.
- NUM_BUF=2, no releases; 3 frames -> frames 1-2 committed, buf_full_o = 11, frame 3 gives no writes, frame_drop_o pulse, drop_cnt_o = 1; release buffer 0, then frame 4 is written to buf 0.
- VSYNC rises after 2 of 3 window lines -> frame_short_o pulse, no frame_done_o, buf_full unchanged; next full frame is written to the same buffer.
- byte_swap_i = 1 at vs_fall, toggled to 0 mid-frame -> whole frame stored as {second, first}, e.g. 0x01A1.
- wRsn low mid-frame for 3 cycles -> all outputs 0 immediately; no writes until the next VSYNC falling edge; the following frame is captured normally into buf 0.
